// File: rtl/qar_i2c_seq.sv
// I2C transaction sequencer: walks one programmed descriptor through the
// qar_i2c controller's register port (START/addr/reg/data/STOP) and raises one irq.
module qar_i2c_seq #(
  parameter int BUF_DEPTH      = 8,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        bus_write,
  input  logic        bus_read,
  input  logic [5:0]  addr_word,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq,
  output logic        m_write,
  output logic        m_read,
  output logic [5:0]  m_addr_word,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata
);

  localparam int         IW     = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam logic [3:0] DEPTH4 = 4'(BUF_DEPTH);

  typedef enum logic [3:0] {
    S_IDLE, S_PUSH, S_CMD, S_HOLD, S_POLL, S_POP, S_NEXT, S_FAIL_STOP, S_DONE
  } state_t;

  typedef enum logic [2:0] {
    PH_START, PH_DEV, PH_REG, PH_DATA, PH_RSTART, PH_RDEV, PH_RBYTE, PH_STOP
  } phase_t;

  state_t state, state_n;
  phase_t phase, phase_n;

  logic [6:0]  dev;
  logic        rd;
  logic [7:0]  reg_addr;
  logic [3:0]  len;
  logic [7:0]  data_buf [BUF_DEPTH];
  logic        busy, done, nack, timeout, aborted;
  logic [3:0]  bytes_done;
  logic [2:0]  irq_en, irq_status, irq_set;
  logic        abort_pend, clr_pend, hold_cnt;
  logic [15:0] tcnt;

  logic host_go, host_abort, desc_we, data_we, data_hit, start;
  logic inc_bytes, rx_store, nack_set, tmo_set, abort_take, clr_done, tmo_hit;
  logic byte_phase;
  logic [7:0] tx_byte;
  logic [3:0] cmd_nib;
  logic unused_bits;

  assign unused_bits = ^{m_rdata[31:8], m_rdata[2:1], wdata[31:20]};

  // DATA[] starts at word 8, a multiple of every legal depth, so the low bits index it
  assign data_hit   = (addr_word >= 6'd8) && (addr_word < 6'(8 + BUF_DEPTH));
  assign host_go    = bus_write && (addr_word == 6'h0) && wdata[0];
  assign host_abort = bus_write && (addr_word == 6'h0) && wdata[1];
  assign desc_we    = bus_write && (addr_word == 6'h1) && !busy;
  assign data_we    = bus_write && data_hit && !busy;
  assign start      = host_go && (state == S_IDLE) && !busy;
  assign tmo_hit    = ({1'b0, tcnt} + 17'd1) >= 17'(TIMEOUT_CYCLES);

  assign byte_phase = (phase == PH_DEV) || (phase == PH_REG) ||
                      (phase == PH_DATA) || (phase == PH_RDEV);

  always_comb begin
    tx_byte = 8'h00;
    case (phase)
      PH_DEV:  tx_byte = {dev, 1'b0};
      PH_REG:  tx_byte = reg_addr;
      PH_DATA: tx_byte = data_buf[bytes_done[IW-1:0]];
      PH_RDEV: tx_byte = {dev, 1'b1};
      default: tx_byte = 8'h00;
    endcase
  end

  always_comb begin
    cmd_nib = 4'h4;
    case (phase)
      PH_START, PH_RSTART: cmd_nib = 4'h1;
      PH_STOP:             cmd_nib = 4'h2;
      PH_RBYTE:            cmd_nib = 4'h8;
      default:             cmd_nib = 4'h4;
    endcase
  end

  function automatic state_t phase_entry(input phase_t p);
    return (p == PH_DEV || p == PH_REG || p == PH_DATA || p == PH_RDEV) ? S_PUSH : S_CMD;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      phase <= PH_START;
    end else begin
      state <= state_n;
      phase <= phase_n;
    end
  end

  // Master strobes come straight from the state so reset silences them at once.
  always_comb begin
    state_n     = state;
    phase_n     = phase;
    m_write     = 1'b0;
    m_read      = 1'b0;
    m_addr_word = 6'd0;
    m_wdata     = 32'd0;
    inc_bytes   = 1'b0;
    rx_store    = 1'b0;
    nack_set    = 1'b0;
    tmo_set     = 1'b0;
    abort_take  = 1'b0;
    clr_done    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          phase_n = PH_START;
          state_n = S_CMD;
        end
      end
      S_PUSH: begin
        m_write     = 1'b1;
        m_addr_word = 6'd5;
        m_wdata     = {24'd0, tx_byte};
        state_n     = S_CMD;
      end
      S_CMD: begin
        m_write     = 1'b1;
        m_addr_word = 6'd7;
        m_wdata     = {28'd0, cmd_nib};
        state_n     = S_HOLD;
      end
      S_HOLD: begin
        if (hold_cnt) state_n = S_POLL;
      end
      S_POLL: begin
        m_read      = 1'b1;
        m_addr_word = 6'd2;
        if (!m_rdata[0]) begin
          if (phase == PH_STOP) begin
            state_n = S_DONE;
          end else if (byte_phase && m_rdata[3]) begin
            nack_set = 1'b1;
            state_n  = S_FAIL_STOP;
          end else if (phase == PH_RBYTE) begin
            state_n = S_POP;
          end else begin
            inc_bytes = (phase == PH_DATA);
            state_n   = S_NEXT;
          end
        end else if (tmo_hit) begin
          // controller presumed wedged: finish without a STOP
          tmo_set = 1'b1;
          state_n = S_DONE;
        end
      end
      S_POP: begin
        m_read      = 1'b1;
        m_addr_word = 6'd6;
        rx_store    = 1'b1;
        inc_bytes   = 1'b1;
        state_n     = S_NEXT;
      end
      S_NEXT: begin
        if (abort_pend) begin
          abort_take = 1'b1;
          state_n    = S_FAIL_STOP;
        end else begin
          case (phase)
            PH_START:  phase_n = PH_DEV;
            PH_DEV:    phase_n = PH_REG;
            PH_REG:    phase_n = (len == 4'd0) ? PH_STOP : (rd ? PH_RSTART : PH_DATA);
            PH_DATA:   phase_n = (bytes_done == len) ? PH_STOP : PH_DATA;
            PH_RSTART: phase_n = PH_RDEV;
            PH_RDEV:   phase_n = PH_RBYTE;
            PH_RBYTE:  phase_n = (bytes_done == len) ? PH_STOP : PH_RBYTE;
            default:   phase_n = PH_STOP;
          endcase
          state_n = phase_entry(phase_n);
        end
      end
      S_FAIL_STOP: begin
        m_write = 1'b1;
        if (clr_pend) begin
          m_addr_word = 6'd2;
          m_wdata     = 32'h8;
          clr_done    = 1'b1;
        end else begin
          m_addr_word = 6'd7;
          m_wdata     = 32'h2;
          phase_n     = PH_STOP;
          state_n     = S_HOLD;
        end
      end
      S_DONE: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  assign irq_set = (state == S_DONE) ? {aborted | abort_pend, nack | timeout, 1'b1} : 3'b000;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dev        <= '0;
      rd         <= 1'b0;
      reg_addr   <= '0;
      len        <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) data_buf[i] <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      nack       <= 1'b0;
      timeout    <= 1'b0;
      aborted    <= 1'b0;
      bytes_done <= '0;
      irq_en     <= '0;
      irq_status <= '0;
      abort_pend <= 1'b0;
      clr_pend   <= 1'b0;
      hold_cnt   <= 1'b0;
      tcnt       <= '0;
    end else begin
      hold_cnt <= (state == S_HOLD) && !hold_cnt;
      tcnt     <= (state == S_POLL) ? tcnt + 16'd1 : 16'd0;
      if (start) begin
        busy       <= 1'b1;
        done       <= 1'b0;
        nack       <= 1'b0;
        timeout    <= 1'b0;
        aborted    <= 1'b0;
        bytes_done <= '0;
        abort_pend <= 1'b0;
        clr_pend   <= 1'b0;
      end
      if (host_abort && busy) abort_pend <= 1'b1;
      if (desc_we) begin
        dev      <= wdata[6:0];
        rd       <= wdata[7];
        reg_addr <= wdata[15:8];
        len      <= (wdata[19:16] > DEPTH4) ? DEPTH4 : wdata[19:16];
      end
      if (data_we)   data_buf[addr_word[IW-1:0]] <= wdata[7:0];
      if (rx_store)  data_buf[bytes_done[IW-1:0]] <= m_rdata[7:0];
      if (inc_bytes) bytes_done <= bytes_done + 4'd1;
      if (nack_set) begin
        nack     <= 1'b1;
        clr_pend <= 1'b1;
      end
      if (clr_done) clr_pend <= 1'b0;
      if (tmo_set)  timeout <= 1'b1;
      if (abort_take) begin
        aborted    <= 1'b1;
        abort_pend <= 1'b0;
      end
      if (state == S_DONE) begin
        busy       <= 1'b0;
        done       <= 1'b1;
        abort_pend <= 1'b0;
        if (abort_pend) aborted <= 1'b1;
      end
      if (bus_write && addr_word == 6'h3) irq_en <= wdata[2:0];
      irq_status <= (irq_status & ~((bus_write && addr_word == 6'h4) ? wdata[2:0] : 3'b000)) | irq_set;
    end
  end

  assign irq = |(irq_en & irq_status);

  always_comb begin
    rdata = 32'd0;
    if (bus_read) begin
      case (addr_word)
        6'h1:    rdata = {12'd0, len, reg_addr, rd, dev};
        6'h2:    rdata = {20'd0, bytes_done, 3'd0, aborted, timeout, nack, done, busy};
        6'h3:    rdata = {29'd0, irq_en};
        6'h4:    rdata = {29'd0, irq_status};
        default: if (data_hit) rdata = {24'd0, data_buf[addr_word[IW-1:0]]};
      endcase
    end
  end

endmodule

// File: tb/tb_qar_i2c_seq.sv
// Bench for qar_i2c_seq: behavioural controller model plus a scoreboard of
// expected master-bus events (TX bytes, CMD words, STATUS clears, RX pops).
module tb_qar_i2c_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        bus_write = 1'b0, bus_read = 1'b0;
  logic [5:0]  addr_word = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        irq;
  logic        m_write, m_read;
  logic [5:0]  m_addr_word;
  logic [31:0] m_wdata, m_rdata;

  always #5 clk = ~clk;

  qar_i2c_seq #(.BUF_DEPTH(8), .TIMEOUT_CYCLES(20)) dut (
    .clk(clk), .rst_n(rst_n), .bus_write(bus_write), .bus_read(bus_read),
    .addr_word(addr_word), .wdata(wdata), .rdata(rdata), .irq(irq),
    .m_write(m_write), .m_read(m_read), .m_addr_word(m_addr_word),
    .m_wdata(m_wdata), .m_rdata(m_rdata)
  );

  int checks = 0;
  int failures = 0;
  logic [11:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // controller model
  logic       wedge = 1'b0, nack_en = 1'b0, ack_err = 1'b0;
  logic [7:0] nack_byte = 8'h00, last_tx = 8'h00;
  logic [7:0] rx_mem [4];
  logic [1:0] rx_idx = 2'd0;
  int         busy_cnt = 0;
  logic       ctl_busy;

  assign ctl_busy = wedge || (busy_cnt != 0);

  always_comb begin
    m_rdata = 32'd0;
    if (m_read && m_addr_word == 6'd2) m_rdata = {28'd0, ack_err, 2'b00, ctl_busy};
    if (m_read && m_addr_word == 6'd6) m_rdata = {24'd0, rx_mem[rx_idx]};
  end

  always @(posedge clk) begin
    if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    if (m_write) begin
      if (m_addr_word == 6'd5) last_tx <= m_wdata[7:0];
      if (m_addr_word == 6'd7) begin
        busy_cnt <= int'($urandom_range(0, 4));
        if (m_wdata[2] && nack_en && last_tx == nack_byte) ack_err <= 1'b1;
      end
      if (m_addr_word == 6'd2 && m_wdata[3]) ack_err <= 1'b0;
    end
    if (m_read && m_addr_word == 6'd6) rx_idx <= rx_idx + 2'd1;
  end

  // monitor / scoreboard
  int         poll_cnt = 0, wr_cmd_cnt = 0;
  logic       both_seen = 1'b0;
  logic [11:0] ev;
  logic       ev_v;

  always @(negedge clk) begin
    if (m_write && m_read) both_seen = 1'b1;
    if (m_read && m_addr_word == 6'd2) poll_cnt++;
    ev_v = 1'b0;
    ev = 12'h000;
    if (m_write && m_addr_word == 6'd5) begin ev = {4'h1, m_wdata[7:0]}; ev_v = 1'b1; end
    if (m_write && m_addr_word == 6'd7) begin ev = {4'h2, m_wdata[7:0]}; ev_v = 1'b1; end
    if (m_write && m_addr_word == 6'd2) begin ev = {4'h3, m_wdata[7:0]}; ev_v = 1'b1; end
    if (m_read && m_addr_word == 6'd6) begin ev = {4'h4, m_rdata[7:0]}; ev_v = 1'b1; end
    if (ev_v) begin
      if (ev == 12'h204) wr_cmd_cnt++;
      if (exp_q.size() == 0) check_eq("unexpected_evt", {20'd0, ev}, 32'hFFF);
      else check_eq("bus_evt", {20'd0, ev}, {20'd0, exp_q.pop_front()});
    end
  end

  task automatic push_cmd(input logic [7:0] c); exp_q.push_back({4'h2, c}); endtask
  task automatic push_tx(input logic [7:0] b);  exp_q.push_back({4'h1, b}); push_cmd(8'h04); endtask
  task automatic push_rx(input logic [7:0] b);  push_cmd(8'h08); exp_q.push_back({4'h4, b}); endtask

  task automatic host_write(input logic [5:0] a, input logic [31:0] d);
    bus_write = 1'b1; addr_word = a; wdata = d;
    @(posedge clk); #1;
    bus_write = 1'b0;
  endtask

  task automatic host_read(input logic [5:0] a, output logic [31:0] d);
    bus_read = 1'b1; addr_word = a;
    @(negedge clk);
    d = rdata;
    @(posedge clk); #1;
    bus_read = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    logic [31:0] s;
    int n = 0;
    do begin
      host_read(6'h2, s);
      n++;
    end while (s[0] && n < 500);
    check_eq({tag, "_idle"}, {31'd0, s[0]}, 32'd0);
  endtask

  task automatic wait_count(input string tag, input int snap, input int need, input bit use_poll);
    int k = 0;
    while (((use_poll ? poll_cnt : wr_cmd_cnt) - snap) < need && k < 400) begin
      @(negedge clk);
      k++;
    end
    check_eq(tag, 32'(((use_poll ? poll_cnt : wr_cmd_cnt) - snap) >= need), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic expect_reg(input string tag, input logic [5:0] a, input logic [31:0] exp);
    logic [31:0] v;
    host_read(a, v);
    check_eq(tag, v, exp);
  endtask

  logic [31:0] rv;
  int snap;

  initial begin
    #1000000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    rx_mem[0] = 8'h11; rx_mem[1] = 8'h22; rx_mem[2] = 8'h33; rx_mem[3] = 8'h44;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_mwrite", {31'd0, m_write}, 32'd0);
    check_eq("rst_mread", {31'd0, m_read}, 32'd0);
    check_eq("rst_maddr", {26'd0, m_addr_word}, 32'd0);
    check_eq("rst_mwdata", m_wdata, 32'd0);
    check_eq("rst_irq", {31'd0, irq}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    expect_reg("rst_status", 6'h2, 32'h0);
    check_eq("rdata_idle", rdata, 32'd0);

    // 1: write transaction
    host_write(6'h3, 32'h1);
    host_write(6'h1, 32'h0002_1050);
    host_write(6'h8, 32'hA5);
    host_write(6'h9, 32'h3C);
    push_cmd(8'h01); push_tx(8'hA0); push_tx(8'h10); push_tx(8'hA5); push_tx(8'h3C); push_cmd(8'h02);
    host_write(6'h0, 32'h1);
    wait_idle("t1");
    expect_reg("t1_status", 6'h2, 32'h202);
    check_eq("t1_irq", {31'd0, irq}, 32'd1);
    expect_reg("t1_irqst", 6'h4, 32'h1);
    check_eq("t1_qempty", exp_q.size(), 32'd0);
    host_write(6'h4, 32'h7);
    check_eq("t1_irq_clr", {31'd0, irq}, 32'd0);

    // 2: read transaction
    rx_idx = 2'd0;
    host_write(6'h1, 32'h0003_20D0);
    push_cmd(8'h01); push_tx(8'hA0); push_tx(8'h20); push_cmd(8'h01); push_tx(8'hA1);
    push_rx(8'h11); push_rx(8'h22); push_rx(8'h33); push_cmd(8'h02);
    host_write(6'h0, 32'h1);
    wait_idle("t2");
    expect_reg("t2_status", 6'h2, 32'h302);
    expect_reg("t2_d0", 6'h8, 32'h11);
    expect_reg("t2_d1", 6'h9, 32'h22);
    expect_reg("t2_d2", 6'hA, 32'h33);
    check_eq("t2_rxreads", {30'd0, rx_idx}, 32'd3);
    check_eq("t2_qempty", exp_q.size(), 32'd0);
    host_write(6'h4, 32'h7);

    // 3: NACK on device address
    nack_en = 1'b1; nack_byte = 8'hA0;
    host_write(6'h3, 32'h7);
    host_write(6'h1, 32'h0001_1050);
    push_cmd(8'h01); push_tx(8'hA0); exp_q.push_back(12'h308); push_cmd(8'h02);
    host_write(6'h0, 32'h1);
    wait_idle("t3");
    expect_reg("t3_status", 6'h2, 32'h006);
    expect_reg("t3_irqst", 6'h4, 32'h3);
    check_eq("t3_irq", {31'd0, irq}, 32'd1);
    check_eq("t3_ackclr", {31'd0, ack_err}, 32'd0);
    check_eq("t3_qempty", exp_q.size(), 32'd0);
    nack_en = 1'b0;
    host_write(6'h4, 32'h7);

    // 4: timeout with wedged controller
    wedge = 1'b1;
    push_cmd(8'h01);
    snap = poll_cnt;
    host_write(6'h0, 32'h1);
    wait_idle("t4");
    expect_reg("t4_status", 6'h2, 32'h00A);
    check_eq("t4_polls", 32'(poll_cnt - snap), 32'd20);
    expect_reg("t4_irqst", 6'h4, 32'h3);
    check_eq("t4_qempty", exp_q.size(), 32'd0);
    wedge = 1'b0;
    host_write(6'h4, 32'h7);

    // 5: abort after two data bytes; GO/DESC/DATA writes while busy are ignored
    for (int i = 0; i < 8; i++) host_write(6'(8 + i), 32'(8'h80 + i));
    host_write(6'h1, 32'h0008_1050);
    push_cmd(8'h01); push_tx(8'hA0); push_tx(8'h10); push_tx(8'h80); push_tx(8'h81); push_cmd(8'h02);
    snap = wr_cmd_cnt;
    host_write(6'h0, 32'h1);
    wait_count("t5_reach_reg", snap, 2, 1'b0);
    host_write(6'h0, 32'h1);
    host_write(6'h1, 32'h0001_2233);
    host_write(6'hD, 32'hFF);
    wait_count("t5_reach_d1", snap, 4, 1'b0);
    host_write(6'h0, 32'h2);
    wait_idle("t5");
    expect_reg("t5_status", 6'h2, 32'h212);
    expect_reg("t5_irqst", 6'h4, 32'h5);
    expect_reg("t5_desc", 6'h1, 32'h0008_1050);
    expect_reg("t5_d5", 6'hD, 32'h85);
    check_eq("t5_qempty", exp_q.size(), 32'd0);
    host_write(6'h4, 32'h7);

    // 6: reset during POLL, then a clean transaction
    wedge = 1'b1;
    host_write(6'h1, 32'h0001_1050);
    push_cmd(8'h01);
    snap = poll_cnt;
    host_write(6'h0, 32'h1);
    wait_count("t6_reach_poll", snap, 3, 1'b1);
    @(negedge clk); #2;
    check_eq("t6_pre_mread", {31'd0, m_read}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("t6_async_mread", {31'd0, m_read}, 32'd0);
    check_eq("t6_async_mwrite", {31'd0, m_write}, 32'd0);
    wedge = 1'b0; busy_cnt = 0; ack_err = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    expect_reg("t6_status", 6'h2, 32'h0);
    check_eq("t6_qempty", exp_q.size(), 32'd0);
    host_write(6'h1, 32'h000F_1050);
    expect_reg("t6_len_clamp", 6'h1, 32'h0008_1050);
    host_write(6'h3, 32'h1);
    host_write(6'h1, 32'h0001_1050);
    host_write(6'h8, 32'h5A);
    push_cmd(8'h01); push_tx(8'hA0); push_tx(8'h10); push_tx(8'h5A); push_cmd(8'h02);
    host_write(6'h0, 32'h1);
    wait_idle("t6");
    expect_reg("t6_status_done", 6'h2, 32'h102);
    check_eq("t6_irq", {31'd0, irq}, 32'd1);
    check_eq("t6_qempty_end", exp_q.size(), 32'd0);

    check_eq("strobe_exclusive", {31'd0, both_seen}, 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/qar_i2c_seq.md
Name: qar_i2c_seq

Overview:
- Transaction sequencer that sits directly upstream of the qar_i2c controller and drives its register port as a bus master.
- The CPU programs one descriptor: 7-bit device address, register address, direction, and up to BUF_DEPTH data bytes, then sets GO.
- The block issues the START / address / register / data / STOP command sequence, polls controller status, and collects read bytes.
- It raises one interrupt when the transaction completes or fails.

Parameters:
- BUF_DEPTH, 8: data buffer bytes (power of two, max 15).
- TIMEOUT_CYCLES, 65535: maximum cycles spent polling for a single controller step before aborting.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset
- bus_write  in  1  host register write strobe
- bus_read  in  1  host register read strobe
- addr_word  in  6  host word address
- wdata  in  32  host write data
- rdata  out  32  host read data, combinational, 0 when !bus_read
- irq  out  1  |(irq_en[2:0] & irq_status[2:0])
- m_write  out  1  controller write strobe
- m_read  out  1  controller read strobe
- m_addr_word  out  6  controller word address
- m_wdata  out  32  controller write data
- m_rdata  in  32  controller read data, valid in the same cycle as m_read

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low. On reset, all registers are 0, the FSM is in IDLE, and m_write, m_read, m_addr_word, m_wdata and irq are all 0.
- Host map:
  - 0x0 CTRL: bit0 GO (self-clearing), bit1 ABORT (self-clearing).
  - 0x1 DESC: [6:0] dev, [7] rd, [15:8] reg, [19:16] len.
  - 0x2 STATUS (RO): bit0 busy, bit1 done, bit2 nack, bit3 timeout, bit4 aborted, [11:8] bytes_done.
  - 0x3 IRQ_EN.
  - 0x4 IRQ_STATUS (W1C): bit0 done, bit1 nack/timeout, bit2 aborted.
  - 0x8 + i DATA[i] (bits [7:0]).
- Writes to DESC or DATA while busy are ignored. GO while busy is ignored.
- len greater than BUF_DEPTH is clamped to BUF_DEPTH.
- Controller map used by this block:
  - CMD at word 7: bit0 START, bit1 STOP, bit2 WRITE, bit3 READ.
  - TX at 5, RX at 6. A read of RX pops one byte.
  - STATUS at 2: bit0 busy, bit3 ack_error. Writing 0x8 to STATUS clears ack_error.
- Master bus rules:
  - At most one access per cycle.
  - m_write and m_read are never high together.
  - Strobes are single-cycle.
- Phase list:
  - Write transaction: START, BYTE(dev<<1), BYTE(reg), BYTE(DATA[0..len-1]), STOP.
  - Read transaction: START, BYTE(dev<<1), BYTE(reg), START, BYTE(dev<<1|1), RBYTE × len, STOP.
  - Read with len 0: STOP follows the reg phase directly, with no repeated START.
- FSM states: IDLE, PUSH, CMD, HOLD, POLL, POP, NEXT, FAIL_STOP, DONE.
- Per-phase sequencing:
  - BYTE phase: PUSH (TX write of the byte) -> CMD (WRITE).
  - START / STOP phase: CMD directly.
  - RBYTE phase: CMD (READ).
  - After CMD: HOLD for exactly 2 cycles, then POLL. POLL reads controller STATUS every cycle until busy = 0.
  - BYTE phase exit: if ack_error = 1, the block writes STATUS 0x8, sets nack, and enters FAIL_STOP. Otherwise it goes to NEXT.
  - RBYTE phase exit: POP reads RX once, stores m_rdata[7:0] into DATA[bytes_done], increments bytes_done, then goes to NEXT.
  - BYTE data-phase exit also increments bytes_done.
- FAIL_STOP issues CMD STOP, then HOLD and POLL, then DONE.
- DONE:
  - busy <= 0 and done <= 1.
  - irq_status bit0 is set, plus bit1 on nack/timeout or bit2 on abort.
  - Returns to IDLE the next cycle.
- GO in IDLE clears done, nack, timeout, aborted and bytes_done, and sets busy. The first controller access occurs on the next cycle.
- ABORT while busy is latched. It is acted on at the next NEXT: sets aborted and enters FAIL_STOP. If the current phase is already STOP, the block completes normally and sets aborted.
- Timeout:
  - A 16-bit counter clears on entry to POLL and increments each POLL cycle.
  - When the counter reaches TIMEOUT_CYCLES, the block sets timeout and goes to DONE with no STOP, because the controller is assumed wedged.
- A host W1C write and an internal set of the same irq_status bit in the same cycle: the set wins.
- Reset mid-transaction returns the block to IDLE immediately. The controller shares rst_n, so no STOP is issued.

Test Plan:
1. Write transaction, ACKing slave: DESC = dev 0x50, wr, reg 0x10, len 2; DATA = {0xA5, 0x3C}; GO. Required: controller receives TX bytes 0xA0, 0x10, 0xA5, 0x3C in order with CMD sequence START, WRITE×4, STOP. Final STATUS: done = 1, bytes_done = 2, nack = 0, irq high with IRQ_EN = 1.
2. Read transaction: dev 0x50, rd, reg 0x20, len 3, slave returns 0x11, 0x22, 0x33. Required: TX bytes 0xA0, 0x20, 0xA1; DATA[0..2] = 0x11, 0x22, 0x33; bytes_done = 3; exactly 3 RX reads.
3. NACK on device address: the slave model leaves SDA high. Required: nack = 1, bytes_done = 0, STATUS write of 0x8 issued, STOP issued, irq_status = 0x3.
4. Timeout: controller busy held at 1, TIMEOUT_CYCLES = 20. Required: timeout = 1 after 20 POLL cycles, no STOP CMD issued, done = 1.
5. ABORT during a len-8 write after 2 data bytes. Required: STOP issued at the next phase boundary, aborted = 1, bytes_done = 2 or 3, irq_status bit2 = 1. GO and DESC writes issued while busy have no effect.
6. Reset asserted during POLL. Required: m_read/m_write drop to 0 asynchronously, STATUS = 0, and a following GO runs cleanly.
